// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer: recovers frame alignment from a sync marker,
// stages slots 00..10 and presents a complete a..d frame with a valid strobe.
module tdm_demux4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             frame_valid,
   output logic             s0,
   output logic             s1,
   output logic             locked,
   output logic             sync_err
);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t           state, state_n;
   logic [1:0]       slot, slot_n;
   logic [WIDTH-1:0] sa, sb, sc;
   logic [WIDTH-1:0] sa_n, sb_n, sc_n;
   logic [WIDTH-1:0] a_n, b_n, c_n, d_n;
   logic             fv_n, err_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         slot        <= '0;
         sa          <= '0;
         sb          <= '0;
         sc          <= '0;
         a           <= '0;
         b           <= '0;
         c           <= '0;
         d           <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state       <= state_n;
         slot        <= slot_n;
         sa          <= sa_n;
         sb          <= sb_n;
         sc          <= sc_n;
         a           <= a_n;
         b           <= b_n;
         c           <= c_n;
         d           <= d_n;
         frame_valid <= fv_n;
         sync_err    <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      slot_n  = slot;
      sa_n    = sa;
      sb_n    = sb;
      sc_n    = sc;
      a_n     = a;
      b_n     = b;
      c_n     = c;
      d_n     = d;
      fv_n    = 1'b0;
      err_n   = 1'b0;
      if (din_valid) begin
         unique case (state)
            HUNT: begin
               if (sync) begin
                  sa_n    = din;
                  slot_n  = 2'd1;
                  state_n = LOCKED;
               end
            end
            LOCKED: begin
               // A sync away from slot 00 drops the partial frame and realigns.
               if (sync && (slot != 2'd0)) begin
                  err_n  = 1'b1;
                  sa_n   = din;
                  slot_n = 2'd1;
               end else begin
                  slot_n = slot + 2'd1;
                  case (slot)
                     2'd0: sa_n = din;
                     2'd1: sb_n = din;
                     2'd2: sc_n = din;
                     2'd3: begin
                        a_n  = sa;
                        b_n  = sb;
                        c_n  = sc;
                        d_n  = din;
                        fv_n = 1'b1;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign locked = (state == LOCKED);
   assign s0     = slot[0];
   assign s1     = slot[1];

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a queue-based frame-assembly model predicts
// per-cycle status and completed frames; a monitor compares after each edge.
module tb_tdm_demux4;
   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         sync = 1'b0;
   logic [W-1:0] a, b, c, d;
   logic         frame_valid, s0, s1, locked, sync_err;

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
      .a(a), .b(b), .c(c), .d(d), .frame_valid(frame_valid),
      .s0(s0), .s1(s1), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         lk;
      logic [1:0]   sl;
      logic         fv;
      logic         er;
      logic [W-1:0] oa, ob, oc, od;
   } st_t;

   st_t              st_q[$];
   logic [4*W-1:0]   fr_q[$];
   int               errors = 0;
   int               checks = 0;

   // reference model: alignment flag, slots collected so far, last frame
   bit               m_locked = 0;
   logic [W-1:0]     m_frame[$];
   logic [W-1:0]     m_out[4] = '{default: '0};

   task automatic model_step();
      st_t e;
      int  n;
      e.fv = 1'b0;
      e.er = 1'b0;
      if (rst) begin
         m_locked = 0;
         m_frame.delete();
         m_out = '{default: '0};
      end else if (din_valid) begin
         if (!m_locked) begin
            if (sync) begin
               m_locked = 1;
               m_frame.push_back(din);
            end
         end else begin
            if (sync && m_frame.size() != 0) begin
               e.er = 1'b1;
               m_frame.delete();
            end
            m_frame.push_back(din);
            if (m_frame.size() == 4) begin
               for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
               fr_q.push_back({m_frame[0], m_frame[1], m_frame[2], m_frame[3]});
               e.fv = 1'b1;
               m_frame.delete();
            end
         end
      end
      n    = m_frame.size();
      e.lk = m_locked;
      e.sl = 2'(n);
      e.oa = m_out[0];
      e.ob = m_out[1];
      e.oc = m_out[2];
      e.od = m_out[3];
      st_q.push_back(e);
   endtask

   task automatic beat(input logic r, input logic v, input logic s, input logic [W-1:0] x);
      @(negedge clk);
      rst       = r;
      din_valid = v;
      sync      = s;
      din       = x;
      model_step();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) beat(1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
   endtask

   // loopback of the 4:1 multiplexer: lane selected by {s1,s0} = 00..11
   task automatic send_frame(input logic [W-1:0] la, input logic [W-1:0] lb,
                             input logic [W-1:0] lc, input logic [W-1:0] ld,
                             input logic with_sync, input int unsigned stall);
      logic [W-1:0] lanes[4];
      lanes[0] = la; lanes[1] = lb; lanes[2] = lc; lanes[3] = ld;
      for (int sel = 0; sel < 4; sel++) begin
         if (sel == 2) idle(stall);
         beat(1'b0, 1'b1, (sel == 0) ? with_sync : 1'b0, lanes[sel]);
      end
   endtask

   always begin
      st_t            exp, act;
      logic [4*W-1:0] f;
      @(posedge clk);
      #1;
      if (st_q.size() != 0) begin
         exp = st_q.pop_front();
         act = {locked, s1, s0, frame_valid, sync_err, a, b, c, d};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL status t=%0t got=%h expected=%h", $time, act, exp);
         end
         if (frame_valid === 1'b1) begin
            checks++;
            if (fr_q.size() == 0) begin
               errors++;
               $display("FAIL frame t=%0t got unexpected frame_valid, expected none", $time);
            end else begin
               f = fr_q.pop_front();
               if ({a, b, c, d} !== f) begin
                  errors++;
                  $display("FAIL frame t=%0t got=%h expected=%h", $time, {a, b, c, d}, f);
               end
            end
         end
      end
   end

   initial begin
      // reset held with active inputs, then sync on the first free edge
      beat(1'b1, 1'b1, 1'b1, 4'h1);
      beat(1'b1, 1'b1, 1'b1, 4'h1);
      send_frame(4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 0);
      // stall between slots 01 and 10
      send_frame(4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 3);
      // back-to-back frames, sync only on the first
      send_frame(4'h1, 4'h0, 4'h1, 4'h0, 1'b1, 0);
      send_frame(4'h0, 4'h1, 4'h1, 4'h0, 1'b0, 0);
      send_frame(4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 0);
      // misplaced sync on the 3rd beat, then a full frame from it
      beat(1'b0, 1'b1, 1'b1, 4'h3);
      beat(1'b0, 1'b1, 1'b0, 4'h5);
      beat(1'b0, 1'b1, 1'b1, 4'h9);
      beat(1'b0, 1'b1, 1'b0, 4'hA);
      beat(1'b0, 1'b1, 1'b0, 4'hB);
      beat(1'b0, 1'b1, 1'b0, 4'hC);
      // reset mid-frame, then sync-free data must not frame
      beat(1'b0, 1'b1, 1'b0, 4'h7);
      beat(1'b0, 1'b1, 1'b0, 4'h8);
      beat(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 8; i++) beat(1'b0, 1'b1, 1'b0, W'($urandom));
      // random traffic
      for (int i = 0; i < 3000; i++)
         beat(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 11) == 0), W'($urandom));
      beat(1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #2;
      checks++;
      if (st_q.size() != 0 || fr_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d/%0d pending expected=0/0", st_q.size(), fr_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1);
   end

endmodule
